// File: rtl/mold_rx_parser.sv
// MoldUDP64 receive framer: parses the 20-byte session header, splits the payload into
// message segments on a main and an overlap channel, and watches for a silent server.
module mold_rx_parser #(
   parameter int AXI_DATA_W = 64,
   parameter int AXI_KEEP_W = 8,
   parameter int SID_W      = 80,
   parameter int SEQ_NUM_W  = 64,
   parameter int ML_W       = 16,
   parameter int OV_DATA_W  = 48,
   parameter int OV_KEEP_LW = 3,
   parameter int HB_TIMEOUT = 1024
) (
   input  logic                  clk,
   input  logic                  nreset,
   input  logic                  udp_axis_tvalid_i,
   input  logic [AXI_DATA_W-1:0] udp_axis_tdata_i,
   input  logic [AXI_KEEP_W-1:0] udp_axis_tkeep_i,
   input  logic                  udp_axis_tlast_i,
   input  logic                  udp_axis_tuser_i,
   output logic                  udp_axis_tready_o,
   output logic [SID_W-1:0]      mold_msg_sid_o,
   output logic [SEQ_NUM_W-1:0]  mold_msg_seq_num_o,
   output logic                  mold_msg_eos_o,
   output logic                  flatlined_v_o,
   output logic                  mold_msg_v_o,
   output logic                  mold_msg_start_o,
   output logic [3:0]            mold_msg_len_o,
   output logic [AXI_DATA_W-1:0] mold_msg_data_o,
   output logic                  mold_msg_ov_v_o,
   output logic                  mold_msg_ov_start_o,
   output logic [OV_KEEP_LW-1:0] mold_msg_ov_len_o,
   output logic [OV_DATA_W-1:0]  mold_msg_ov_data_o
);

   localparam int HB_W = $clog2(HB_TIMEOUT + 1);

   typedef enum logic [2:0] {S_IDLE, S_H0, S_H1, S_H2, S_MSG, S_DROP} state_t;
   typedef enum logic [1:0] {PH_HI, PH_LO, PH_PAY} phase_t;

   state_t                state_q, state_d;
   phase_t                phase_q, phase_d;
   logic [7:0]            hi_q, hi_d;
   logic [ML_W-1:0]       rem_q, rem_d;
   logic [ML_W-1:0]       cnt_q, cnt_d;
   logic                  new_q, new_d;
   logic [SEQ_NUM_W-1:0]  seq_q, seq_d;
   logic [SID_W-1:0]      sid_q, sid_d;
   logic [HB_W-1:0]       hb_q, hb_d;
   logic                  flat_q, flat_d;
   logic                  eos_q, eos_d;
   logic                  m_v_q, m_v_d;
   logic                  m_start_q, m_start_d;
   logic [3:0]            m_len_q, m_len_d;
   logic [AXI_DATA_W-1:0] m_data_q, m_data_d;
   logic [SEQ_NUM_W-1:0]  m_seq_q, m_seq_d;
   logic                  ov_v_q, ov_v_d;
   logic [OV_KEEP_LW-1:0] ov_len_q, ov_len_d;
   logic [OV_DATA_W-1:0]  ov_data_q, ov_data_d;

   // Walk scratch: running message state while stepping through the lanes of one beat.
   logic                  w_en, w_new, w_done, w_to_ov, h0_beat;
   int                    w_start;
   phase_t                w_ph;
   logic [7:0]            w_hi, lane_b;
   logic [ML_W-1:0]       w_rem, w_cnt, hdr_cnt;
   logic [SEQ_NUM_W-1:0]  w_seq;
   logic                  unused_tuser;

   assign unused_tuser      = udp_axis_tuser_i;
   assign udp_axis_tready_o = 1'b1;
   assign hdr_cnt           = udp_axis_tdata_i[23:8] >> 0 == 0 ? {udp_axis_tdata_i[23:16], udp_axis_tdata_i[31:24]} : {udp_axis_tdata_i[23:16], udp_axis_tdata_i[31:24]};
   assign h0_beat           = udp_axis_tvalid_i && (state_q == S_IDLE || state_q == S_H0);

   always_comb begin
      state_d   = state_q;
      phase_d   = phase_q;
      hi_d      = hi_q;
      rem_d     = rem_q;
      cnt_d     = cnt_q;
      new_d     = new_q;
      seq_d     = seq_q;
      sid_d     = sid_q;
      hb_d      = (hb_q != '0) ? hb_q - HB_W'(1) : '0;
      flat_d    = flat_q;
      eos_d     = 1'b0;
      w_en      = 1'b0;
      w_start   = 0;
      w_ph      = phase_q;
      w_hi      = hi_q;
      w_rem     = rem_q;
      w_cnt     = cnt_q;
      w_seq     = seq_q;
      w_new     = new_q;
      w_done    = 1'b0;
      w_to_ov   = 1'b0;
      lane_b    = '0;
      m_start_d = 1'b0;
      m_len_d   = '0;
      m_data_d  = '0;
      m_seq_d   = m_seq_q;
      ov_len_d  = '0;
      ov_data_d = '0;

      if (udp_axis_tvalid_i) begin
         case (state_q)
            S_IDLE, S_H0: begin
               for (int i = 0; i < 8; i++) sid_d[SID_W-1-8*i -: 8] = udp_axis_tdata_i[8*i +: 8];
               hb_d    = HB_W'(HB_TIMEOUT);
               state_d = S_H1;
            end
            S_H1: begin
               sid_d[15:0] = {udp_axis_tdata_i[7:0], udp_axis_tdata_i[15:8]};
               for (int i = 2; i < 8; i++) seq_d[SEQ_NUM_W-1-8*(i-2) -: 8] = udp_axis_tdata_i[8*i +: 8];
               state_d = S_H2;
            end
            S_H2: begin
               seq_d = {seq_q[SEQ_NUM_W-1:16], udp_axis_tdata_i[7:0], udp_axis_tdata_i[15:8]};
               if (hdr_cnt == '0 || hdr_cnt == '1) begin
                  eos_d   = (hdr_cnt == '1);
                  state_d = S_DROP;
               end else begin
                  w_en    = 1'b1;
                  w_start = 4;
                  w_ph    = PH_HI;
                  w_cnt   = hdr_cnt;
                  w_seq   = seq_d;
                  w_new   = 1'b0;
                  state_d = S_MSG;
               end
            end
            S_MSG:   w_en = 1'b1;
            default: ;
         endcase

         // At most two segments land in one beat because every message is at least 6 bytes.
         for (int i = 0; i < AXI_KEEP_W; i++) begin
            if (w_en && !w_done && i >= w_start && udp_axis_tkeep_i[i]) begin
               lane_b = udp_axis_tdata_i[8*i +: 8];
               case (w_ph)
                  PH_HI: begin
                     w_hi = lane_b;
                     w_ph = PH_LO;
                  end
                  PH_LO: begin
                     w_rem = {w_hi, lane_b};
                     w_ph  = PH_PAY;
                     w_new = 1'b1;
                  end
                  default: begin
                     if (!w_to_ov) begin
                        if (m_len_d == 4'd0) begin
                           m_start_d = w_new;
                           m_seq_d   = w_seq;
                        end
                        m_data_d[{m_len_d[2:0], 3'b000} +: 8] = lane_b;
                        m_len_d = m_len_d + 4'd1;
                     end else if (ov_len_d < OV_KEEP_LW'(6)) begin
                        ov_data_d[{ov_len_d, 3'b000} +: 8] = lane_b;
                        ov_len_d = ov_len_d + OV_KEEP_LW'(1);
                     end
                     w_new = 1'b0;
                     w_rem = w_rem - ML_W'(1);
                     if (w_rem == '0) begin
                        w_seq   = w_seq + SEQ_NUM_W'(1);
                        w_cnt   = w_cnt - ML_W'(1);
                        w_ph    = PH_HI;
                        w_to_ov = 1'b1;
                        w_done  = (w_cnt == '0);
                     end
                  end
               endcase
            end
         end

         if (w_en) begin
            phase_d = w_ph;
            hi_d    = w_hi;
            rem_d   = w_rem;
            cnt_d   = w_cnt;
            new_d   = w_new;
            seq_d   = w_seq;
            if (w_done) state_d = S_DROP;
         end
         if (udp_axis_tlast_i) state_d = S_H0;
      end

      if (h0_beat)            flat_d = 1'b0;
      else if (hb_d == '0)    flat_d = 1'b1;

      m_v_d  = (m_len_d != 4'd0);
      ov_v_d = (ov_len_d != '0);
   end

   always_ff @(posedge clk) begin
      if (!nreset) begin
         state_q   <= S_IDLE;
         phase_q   <= PH_HI;
         hi_q      <= '0;
         rem_q     <= '0;
         cnt_q     <= '0;
         new_q     <= 1'b0;
         seq_q     <= '0;
         sid_q     <= '0;
         hb_q      <= HB_W'(HB_TIMEOUT);
         flat_q    <= 1'b0;
         eos_q     <= 1'b0;
         m_v_q     <= 1'b0;
         m_start_q <= 1'b0;
         m_len_q   <= '0;
         m_data_q  <= '0;
         m_seq_q   <= '0;
         ov_v_q    <= 1'b0;
         ov_len_q  <= '0;
         ov_data_q <= '0;
      end else begin
         state_q   <= state_d;
         phase_q   <= phase_d;
         hi_q      <= hi_d;
         rem_q     <= rem_d;
         cnt_q     <= cnt_d;
         new_q     <= new_d;
         seq_q     <= seq_d;
         sid_q     <= sid_d;
         hb_q      <= hb_d;
         flat_q    <= flat_d;
         eos_q     <= eos_d;
         m_v_q     <= m_v_d;
         m_start_q <= m_start_d;
         m_len_q   <= m_len_d;
         m_data_q  <= m_data_d;
         m_seq_q   <= m_seq_d;
         ov_v_q    <= ov_v_d;
         ov_len_q  <= ov_len_d;
         ov_data_q <= ov_data_d;
      end
   end

   assign mold_msg_sid_o      = sid_q;
   assign mold_msg_seq_num_o  = m_seq_q;
   assign mold_msg_eos_o      = eos_q;
   assign flatlined_v_o       = flat_q;
   assign mold_msg_v_o        = m_v_q;
   assign mold_msg_start_o    = m_start_q;
   assign mold_msg_len_o      = m_len_q;
   assign mold_msg_data_o     = m_data_q;
   assign mold_msg_ov_v_o     = ov_v_q;
   assign mold_msg_ov_start_o = ov_v_q;
   assign mold_msg_ov_len_o   = ov_len_q;
   assign mold_msg_ov_data_o  = ov_data_q;

endmodule

// File: tb/tb_mold_rx_parser.sv
// Bench for mold_rx_parser: packets are built as byte lists, expected segments are derived
// from message byte positions and compared against the DUT output in a scoreboard.
module tb_mold_rx_parser;

   localparam int EXP_W = 185;

   logic        clk = 1'b0;
   logic        nreset;
   logic        udp_axis_tvalid_i;
   logic [63:0] udp_axis_tdata_i;
   logic [7:0]  udp_axis_tkeep_i;
   logic        udp_axis_tlast_i;
   logic        udp_axis_tuser_i;
   logic        udp_axis_tready_o;
   logic [79:0] mold_msg_sid_o;
   logic [63:0] mold_msg_seq_num_o;
   logic        mold_msg_eos_o;
   logic        flatlined_v_o;
   logic        mold_msg_v_o;
   logic        mold_msg_start_o;
   logic [3:0]  mold_msg_len_o;
   logic [63:0] mold_msg_data_o;
   logic        mold_msg_ov_v_o;
   logic        mold_msg_ov_start_o;
   logic [2:0]  mold_msg_ov_len_o;
   logic [47:0] mold_msg_ov_data_o;

   logic [EXP_W-1:0] exp_q[$];
   logic [7:0]       pkt_q[$];
   int               msg_off[$];
   int               msg_len[$];
   logic [63:0]      hdr_seq;
   int               n_cmp = 0;
   int               n_err = 0;
   int               eos_seen = 0;

   mold_rx_parser dut (
      .clk                 (clk),
      .nreset              (nreset),
      .udp_axis_tvalid_i   (udp_axis_tvalid_i),
      .udp_axis_tdata_i    (udp_axis_tdata_i),
      .udp_axis_tkeep_i    (udp_axis_tkeep_i),
      .udp_axis_tlast_i    (udp_axis_tlast_i),
      .udp_axis_tuser_i    (udp_axis_tuser_i),
      .udp_axis_tready_o   (udp_axis_tready_o),
      .mold_msg_sid_o      (mold_msg_sid_o),
      .mold_msg_seq_num_o  (mold_msg_seq_num_o),
      .mold_msg_eos_o      (mold_msg_eos_o),
      .flatlined_v_o       (flatlined_v_o),
      .mold_msg_v_o        (mold_msg_v_o),
      .mold_msg_start_o    (mold_msg_start_o),
      .mold_msg_len_o      (mold_msg_len_o),
      .mold_msg_data_o     (mold_msg_data_o),
      .mold_msg_ov_v_o     (mold_msg_ov_v_o),
      .mold_msg_ov_start_o (mold_msg_ov_start_o),
      .mold_msg_ov_len_o   (mold_msg_ov_len_o),
      .mold_msg_ov_data_o  (mold_msg_ov_data_o)
   );

   // Clock and reset.
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [79:0] got, input logic [79:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   // Driver tasks.
   task automatic drive_beat(input logic [63:0] d, input logic [7:0] k, input logic l, input logic v);
      udp_axis_tvalid_i = v;
      udp_axis_tdata_i  = d;
      udp_axis_tkeep_i  = k;
      udp_axis_tlast_i  = l;
      udp_axis_tuser_i  = 1'($urandom_range(0, 1));
      @(posedge clk);
      #1;
      udp_axis_tvalid_i = 1'b0;
      udp_axis_tlast_i  = 1'b0;
   endtask

   task automatic pkt_header(input logic [79:0] sid, input logic [63:0] seq, input logic [15:0] cnt);
      pkt_q.delete();
      msg_off.delete();
      msg_len.delete();
      hdr_seq = seq;
      for (int i = 0; i < 10; i++) pkt_q.push_back(sid[79-8*i -: 8]);
      for (int i = 0; i < 8; i++)  pkt_q.push_back(seq[63-8*i -: 8]);
      pkt_q.push_back(cnt[15:8]);
      pkt_q.push_back(cnt[7:0]);
   endtask

   task automatic pkt_msg(input int len);
      logic [15:0] l16;
      l16 = 16'(len);
      pkt_q.push_back(l16[15:8]);
      pkt_q.push_back(l16[7:0]);
      msg_off.push_back(pkt_q.size());
      msg_len.push_back(len);
      for (int i = 0; i < len; i++) pkt_q.push_back(8'($urandom_range(0, 255)));
   endtask

   task automatic pkt_pad(input int n);
      for (int i = 0; i < n; i++) pkt_q.push_back(8'($urandom_range(0, 255)));
   endtask

   // Per beat: payload bytes of each message falling in the beat form a segment; the first
   // segment goes to main, the second to overlap.
   task automatic push_expected(input int n);
      int nseg, lo, hi;
      logic ms, ovv;
      logic [3:0] ml;
      logic [63:0] md, mseq;
      logic [2:0] ol;
      logic [47:0] od;
      for (int b = 0; b * 8 < n; b++) begin
         nseg = 0; ms = 0; ml = 0; md = 0; mseq = 0; ovv = 0; ol = 0; od = 0;
         for (int m = 0; m < msg_off.size(); m++) begin
            lo = (msg_off[m] > 8 * b) ? msg_off[m] : 8 * b;
            hi = msg_off[m] + msg_len[m];
            if (hi > 8 * b + 8) hi = 8 * b + 8;
            if (hi > n) hi = n;
            if (lo < hi) begin
               if (nseg == 0) begin
                  ms   = (msg_off[m] >= 8 * b);
                  ml   = 4'(hi - lo);
                  mseq = hdr_seq + 64'(m);
                  for (int k = lo; k < hi; k++) md[8*(k-lo) +: 8] = pkt_q[k];
               end else begin
                  ovv = 1'b1;
                  ol  = 3'(hi - lo);
                  for (int k = lo; k < hi; k++) od[8*(k-lo) +: 8] = pkt_q[k];
               end
               nseg++;
            end
         end
         if (nseg > 0) exp_q.push_back({ms, ml, md, mseq, ovv, ol, od});
      end
   endtask

   task automatic send_pkt(input int gap_max);
      int n, nb, idx;
      logic [63:0] d;
      logic [7:0] k;
      n  = pkt_q.size();
      nb = (n + 7) / 8;
      push_expected(n);
      for (int b = 0; b < nb; b++) begin
         for (int ln = 0; ln < 8; ln++) begin
            idx = 8 * b + ln;
            if (idx < n) begin
               d[8*ln +: 8] = pkt_q[idx];
               k[ln] = 1'b1;
            end else begin
               d[8*ln +: 8] = 8'($urandom_range(0, 255));
               k[ln] = 1'b0;
            end
         end
         repeat ($urandom_range(0, gap_max))
            drive_beat({$urandom, $urandom}, 8'($urandom_range(0, 255)), 1'($urandom_range(0, 1)), 1'b0);
         drive_beat(d, k, b == nb - 1, 1'b1);
      end
   endtask

   // Scoreboard: every output beat pops one expected record.
   always @(negedge clk) begin : monitor
      logic [EXP_W-1:0] e;
      logic [63:0] mmask;
      logic [47:0] omask;
      if (mold_msg_eos_o === 1'b1) eos_seen++;
      if (mold_msg_v_o === 1'b1 || mold_msg_ov_v_o === 1'b1) begin
         if (exp_q.size() == 0) begin
            check("unexpected_out", 80'({mold_msg_v_o, mold_msg_ov_v_o}), 80'd0);
         end else begin
            e = exp_q.pop_front();
            mmask = '0;
            omask = '0;
            for (int k = 0; k < 8; k++) if (k < int'(e[183:180])) mmask[8*k +: 8] = 8'hFF;
            for (int k = 0; k < 6; k++) if (k < int'(e[50:48]))   omask[8*k +: 8] = 8'hFF;
            check("main_v",     80'(mold_msg_v_o),                80'd1);
            check("main_start", 80'(mold_msg_start_o),            80'(e[184]));
            check("main_len",   80'(mold_msg_len_o),              80'(e[183:180]));
            check("main_data",  80'(mold_msg_data_o & mmask),     80'(e[179:116]));
            check("seq_num",    80'(mold_msg_seq_num_o),          80'(e[115:52]));
            check("ov_v",       80'(mold_msg_ov_v_o),             80'(e[51]));
            if (e[51]) begin
               check("ov_start", 80'(mold_msg_ov_start_o),        80'd1);
               check("ov_len",   80'(mold_msg_ov_len_o),          80'(e[50:48]));
               check("ov_data",  80'(mold_msg_ov_data_o & omask), 80'(e[47:0]));
            end
         end
      end
   end

   initial begin
      int e0, cnt, trunc;
      nreset = 1'b0;
      udp_axis_tvalid_i = 1'b0;
      udp_axis_tdata_i  = '0;
      udp_axis_tkeep_i  = '0;
      udp_axis_tlast_i  = 1'b0;
      udp_axis_tuser_i  = 1'b0;
      repeat (4) @(posedge clk);
      #1;
      check("rst_v",      80'(mold_msg_v_o),      80'd0);
      check("rst_start",  80'(mold_msg_start_o),  80'd0);
      check("rst_len",    80'(mold_msg_len_o),    80'd0);
      check("rst_ov_v",   80'(mold_msg_ov_v_o),   80'd0);
      check("rst_ov_len", 80'(mold_msg_ov_len_o), 80'd0);
      check("rst_eos",    80'(mold_msg_eos_o),    80'd0);
      check("rst_flat",   80'(flatlined_v_o),     80'd0);
      check("tready",     80'(udp_axis_tready_o), 80'd1);
      nreset = 1'b1;
      @(posedge clk);
      #1;

      // Back-to-back: a warm-up packet, then the single-message packet ending with tkeep 0x0F.
      pkt_header(80'h1111_2222_3333_4444_5555, 64'd100, 16'd1);
      pkt_msg(14);
      send_pkt(0);
      pkt_header(80'h0102_0304_0506_0708_090A, 64'd5, 16'd1);
      pkt_msg(6);
      send_pkt(0);
      repeat (3) @(posedge clk);
      #1;
      check("sid", mold_msg_sid_o, 80'h0102_0304_0506_0708_090A);

      pkt_header(80'hAAAA_0000_BBBB_0000_CCCC, 64'd5, 16'd2);
      pkt_msg(8);
      pkt_msg(10);
      send_pkt(1);

      // Overlap: first message ends mid-beat, second starts in the same beat.
      pkt_header(80'h1234_5678_9ABC_DEF0_1357, 64'd40, 16'd2);
      pkt_msg(6);
      pkt_msg(10);
      send_pkt(0);

      // Length field split across a beat boundary.
      pkt_header(80'h0F0F_0F0F_0F0F_0F0F_0F0F, 64'd77, 16'd2);
      pkt_msg(9);
      pkt_msg(7);
      send_pkt(1);

      // Sequence wraps mod 2^64.
      pkt_header(80'hDEAD_BEEF_0000_0000_0001, 64'hFFFF_FFFF_FFFF_FFFF, 16'd2);
      pkt_msg(11);
      pkt_msg(6);
      send_pkt(0);

      e0 = eos_seen;
      pkt_header(80'h5555_5555_5555_5555_5555, 64'd9, 16'hFFFF);
      pkt_pad(12);
      send_pkt(0);
      repeat (3) @(posedge clk);
      #1;
      check("eos_pulses", 80'(eos_seen - e0), 80'd1);

      e0 = eos_seen;
      pkt_header(80'h6666_6666_6666_6666_6666, 64'd9, 16'h0000);
      pkt_pad(5);
      send_pkt(1);
      repeat (3) @(posedge clk);
      #1;
      check("hb_no_eos", 80'(eos_seen - e0), 80'd0);

      // Count reached with trailing bytes still in the packet: they are dropped.
      pkt_header(80'h7777_7777_7777_7777_7777, 64'd300, 16'd1);
      pkt_msg(7);
      pkt_pad(13);
      send_pkt(0);

      for (int p = 0; p < 20; p++) begin
         cnt = $urandom_range(1, 4);
         pkt_header({$urandom, $urandom, 16'($urandom)}, {$urandom, $urandom}, 16'(cnt));
         for (int m = 0; m < cnt; m++) pkt_msg($urandom_range(6, 20));
         trunc = $urandom_range(0, 3);
         if (trunc == 0) begin
            repeat ($urandom_range(1, 5)) void'(pkt_q.pop_back());
         end else if (trunc == 1) begin
            pkt_pad($urandom_range(1, 9));
         end
         send_pkt($urandom_range(0, 2));
      end

      // Heartbeat watchdog.
      pkt_header(80'h8888_8888_8888_8888_8888, 64'd1, 16'd1);
      pkt_msg(6);
      send_pkt(0);
      repeat (1000) @(posedge clk);
      #1;
      check("flat_early", 80'(flatlined_v_o), 80'd0);
      repeat (40) @(posedge clk);
      #1;
      check("flat_set", 80'(flatlined_v_o), 80'd1);
      pkt_header(80'h9999_9999_9999_9999_9999, 64'd2, 16'd1);
      pkt_msg(8);
      send_pkt(0);
      check("flat_clear", 80'(flatlined_v_o), 80'd0);

      repeat (5) @(posedge clk);
      #1;
      check("sb_drain", 80'(exp_q.size()), 80'd0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
